neuron_core: RTL and testbench



---
 rtl/nn_pkg.sv | 41 ++++
 rtl/neuron_mac_tree.sv | 33 +++
 rtl/neuron_core.sv | 73 +++++++
 tb/tb_neuron_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and helpers for the NETWORK1 neuron datapath.
package nn_pkg;

  localparam int unsigned NN_WIDTH = 16;
  localparam int unsigned NN_N     = 8;
  localparam int unsigned NN_FRAC  = 8;

  // Upper bounds the helpers are sized for; instances must stay within them.
  localparam int unsigned MAX_W    = 32;
  localparam int unsigned MAX_FLAT = 2048;

  typedef logic signed [2*MAX_W-1:0] wide_t;

  // Arithmetic right shift by frac, then clamp to a signed width-bit range.
  function automatic wide_t sat_shift(input wide_t value, input int unsigned frac,
                                      input int unsigned width);
    wide_t shifted;
    wide_t hi;
    wide_t lo;
    shifted = value >>> frac;
    hi      = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo      = -hi - wide_t'(1);
    if (shifted > hi) begin
      return hi;
    end else if (shifted < lo) begin
      return lo;
    end
    return shifted;
  endfunction

  // Weight i of an n-entry flat vector, entry 0 in the MSBs, sign-extended.
  function automatic logic signed [MAX_W-1:0] weight_at(input logic [MAX_FLAT-1:0] flat,
                                                        input int unsigned i,
                                                        input int unsigned n,
                                                        input int unsigned width);
    logic signed [MAX_FLAT-1:0] aligned;
    aligned = $signed(flat << (MAX_FLAT - (n - i) * width));
    return MAX_W'(aligned >>> (MAX_FLAT - width));
  endfunction

endpackage

// File: rtl/neuron_mac_tree.sv
// Registered N-way signed adder of full-width products; wraps on overflow.
module neuron_mac_tree
  import nn_pkg::*;
#(
  parameter int unsigned WIDTH = NN_WIDTH,
  parameter int unsigned N     = NN_N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic signed [2*WIDTH-1:0] terms [0:N-1],
  output logic signed [2*WIDTH-1:0] sum,
  output logic signed [2*WIDTH-1:0] sum_c
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) begin
      sum_c = sum_c + terms[IW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_c;
    end
  end

endmodule

// File: rtl/neuron_core.sv
// Fixed-weight neuron: multiply stage, accumulate + rescale/saturate stage.
module neuron_core
  import nn_pkg::*;
#(
  parameter int unsigned               WIDTH        = NN_WIDTH,
  parameter int unsigned               N            = NN_N,
  parameter int unsigned               FRAC         = NN_FRAC,
  parameter logic signed [WIDTH*N-1:0] WEIGHTS_FLAT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in [0:N-1],
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic signed [WIDTH-1:0] w        [0:N-1];
  logic signed [PW-1:0]    products [0:N-1];
  logic signed [PW-1:0]    sum;
  logic signed [PW-1:0]    sum_c;
  logic                    v1;

  for (genvar i = 0; i < N; i++) begin : g_weight
    assign w[i] = WIDTH'(weight_at(MAX_FLAT'(WEIGHTS_FLAT), i, N, WIDTH));
  end

  // Stage 1: full-precision products, held while no vector is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        products[IW'(i)] <= '0;
      end
      v1 <= 1'b0;
    end else begin
      if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          products[IW'(i)] <= PW'(in[IW'(i)]) * PW'(w[IW'(i)]);
        end
      end
      v1 <= in_valid;
    end
  end

  neuron_mac_tree #(
    .WIDTH(WIDTH),
    .N    (N)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (v1),
    .terms(products),
    .sum  (sum),
    .sum_c(sum_c)
  );

  // Stage 2: result is taken from the same sum being registered this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        out <= WIDTH'(sat_shift(wide_t'(sum_c), FRAC, WIDTH));
      end
    end
  end

endmodule

// File: tb/tb_neuron_core.sv
// Bench for neuron_core: directed cases plus randomized traffic against a reference model.
module tb_neuron_core;

  localparam int NIN = 8;

  localparam logic [127:0] WF0 = {16'h0C00, 16'h1E80, 16'hF600, 16'hFFB3,
                                  16'h0C00, 16'h1E80, 16'hF600, 16'hFFB3};
  localparam logic [127:0] WF1 = {8{16'h7FFF}};

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] vin [0:NIN-1];
  logic               ov0, ov1;
  logic signed [15:0] out0, out1;

  int checks = 0;
  int fails  = 0;

  int w0 [NIN] = '{3072, 7808, -2560, -77, 3072, 7808, -2560, -77};
  int w1 [NIN] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
  int case1 [NIN] = '{-384, 358, -77, 2586, -384, 358, -77, 2586};

  always #5 clk = ~clk;

  neuron_core #(.WIDTH(16), .N(8), .FRAC(8), .WEIGHTS_FLAT(WF0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(vin), .out_valid(ov0), .out(out0)
  );

  neuron_core #(.WIDTH(16), .N(8), .FRAC(8), .WEIGHTS_FLAT(WF1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(vin), .out_valid(ov1), .out(out1)
  );

  // Dot product wrapped to 32 bits, floor-divided by 256, clamped to 16 bits.
  function automatic int ref_out(input int x [NIN], input int w [NIN]);
    longint acc = 0;
    int     s;
    int     sh;
    for (int i = 0; i < NIN; i++) acc += longint'(x[i]) * longint'(w[i]);
    s  = int'(acc);
    sh = s >>> 8;
    if (sh > 32767) return 32767;
    if (sh < -32768) return -32768;
    return sh;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int v [NIN]);
    for (int i = 0; i < NIN; i++) vin[i] = 16'(v[i]);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NIN; i++) vin[i] = 16'(v);
  endtask

  // Reference: each accepted vector yields its result one edge after it is sampled.
  typedef struct {
    int due;
    int r0;
    int r1;
  } pend_t;

  pend_t q[$];
  int    edge_cnt = 0;
  bit    m_valid  = 1'b0;
  int    m_out0   = 0;
  int    m_out1   = 0;

  always @(posedge clk) begin
    int    x [NIN];
    pend_t p;
    edge_cnt++;
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
      m_out0  = 0;
      m_out1  = 0;
    end else begin
      m_valid = 1'b0;
      if (q.size() > 0 && q[0].due == edge_cnt) begin
        p       = q.pop_front();
        m_valid = 1'b1;
        m_out0  = p.r0;
        m_out1  = p.r1;
      end
      if (in_valid) begin
        for (int i = 0; i < NIN; i++) x[i] = int'(vin[i]);
        q.push_back('{edge_cnt + 1, ref_out(x, w0), ref_out(x, w1)});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("out_valid", int'(ov0), int'(m_valid));
    chk("out", int'(out0), m_out0);
    chk("sat_out_valid", int'(ov1), int'(m_valid));
    chk("sat_out", int'(out1), m_out1);
  end

  initial begin
    set_all(0);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    chk("reset_out_valid", int'(ov0), 0);
    chk("reset_out", int'(out0), 0);
    chk("reset_sum", int'(dut.sum), 0);
    chk("reset_product0", int'(dut.products[0]), 0);
    rst = 1'b0;
    tick();

    // Single vector: products after one edge, result after the next.
    set_vec(case1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_product0", int'(dut.products[0]), -1179648);
    chk("t1_product1", int'(dut.products[1]), 2795264);
    chk("t1_product2", int'(dut.products[2]), 197120);
    chk("t1_product3", int'(dut.products[3]), -199122);
    chk("t1_product4", int'(dut.products[4]), -1179648);
    chk("t1_early_valid", int'(ov0), 0);
    tick();
    chk("t1_valid", int'(ov0), 1);
    chk("t1_sum", int'(dut.sum), 3227228);
    chk("t1_out", int'(out0), 12606);
    tick();
    chk("t1_valid_drop", int'(ov0), 0);

    // Zero vector.
    set_all(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t2_valid", int'(ov0), 1);
    chk("t2_sum", int'(dut.sum), 0);
    chk("t2_out", int'(out0), 0);

    // Saturation on the all-32767 instance, both directions back to back.
    set_all(4096);
    in_valid = 1'b1;
    tick();
    set_all(-4096);
    tick();
    in_valid = 1'b0;
    chk("t3_sum_pos", int'(dut_sat.sum), 1073709056);
    chk("t3_out_pos", int'(out1), 32767);
    tick();
    chk("t3_sum_neg", int'(dut_sat.sum), -1073709056);
    chk("t3_out_neg", int'(out1), -32768);
    tick();

    // Three back-to-back vectors.
    set_vec(case1);
    in_valid = 1'b1;
    tick();
    set_all(0);
    tick();
    chk("t4_out_a", int'(out0), 12606);
    set_vec(case1);
    tick();
    chk("t4_out_b", int'(out0), 0);
    chk("t4_valid_b", int'(ov0), 1);
    in_valid = 1'b0;
    tick();
    chk("t4_out_c", int'(out0), 12606);
    chk("t4_valid_c", int'(ov0), 1);

    // Idle: result holds while out_valid stays low.
    set_all(1000);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_hold_out", int'(out0), 12606);
      chk("t6_hold_valid", int'(ov0), 0);
    end

    // Reset with two vectors in flight.
    set_vec(case1);
    in_valid = 1'b1;
    tick();
    set_all(0);
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", int'(ov0), 0);
    chk("t5_rst_out", int'(out0), 0);
    chk("t5_rst_sat_out", int'(out1), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("t5_no_stale_1", int'(ov0), 0);
    tick();
    chk("t5_no_stale_2", int'(ov0), 0);
    set_vec(case1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_after_valid", int'(ov0), 1);
    chk("t5_after_out", int'(out0), 12606);

    // Randomized traffic, including occasional resets and full-range values.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      in_valid = $urandom_range(0, 2) != 0;
      for (int i = 0; i < NIN; i++) begin
        if ($urandom_range(0, 3) == 0) vin[i] = 16'($urandom);
        else vin[i] = 16'(int'($urandom_range(0, 1200)) - 600);
      end
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
